// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: control-word bit positions,
// access size encodings, FSM states and byte-lane mask helpers.
package mem_pkg;

    localparam int CST_LD = 5;
    localparam int CST_ST = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = MASK_B;
            SZ_H:    m = MASK_H;
            SZ_W:    m = MASK_W;
            default: m = MASK_D;
        endcase
        return m;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] off_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SZ_B:    m = 3'b000;
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port bundle between mem_stage (master) and the data memory (slave).
interface mem_stage_if #(
    parameter int XLEN = 64
);
    // Single-outstanding handshake: the master raises DMEM_REQ with WE/ADDR/
    // WDATA/WMASK and holds all of them constant until the slave pulses
    // DMEM_ACK for one cycle; read data is valid in that same ACK cycle.
    logic            DMEM_REQ;
    logic            DMEM_WE;
    logic [XLEN-1:0] DMEM_ADDR;
    logic [XLEN-1:0] DMEM_WDATA;
    logic [7:0]      DMEM_WMASK;
    logic            DMEM_ACK;
    logic [XLEN-1:0] DMEM_RDATA;

    modport master (
        output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WMASK,
        input  DMEM_ACK, DMEM_RDATA
    );

    modport slave (
        input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WMASK,
        output DMEM_ACK, DMEM_RDATA
    );

endinterface

// File: rtl/load_align.sv
// Load data alignment: selects the addressed byte lanes of a read doubleword
// and sign- or zero-extends the result to 64 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [63:0] data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        data    = shifted;
        case (size)
            SZ_B:    data = {{56{~uns & shifted[7]}},  shifted[7:0]};
            SZ_H:    data = {{48{~uns & shifted[15]}}, shifted[15:0]};
            SZ_W:    data = {{32{~uns & shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers execute results, runs one load/store
// at a time on the data-memory port and aligns load data for writeback.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of masking.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CST_W = 19
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MEM_V,
    input  logic [CST_W-1:0] MEM_Cst,
    input  logic [XLEN-1:0]  MEM_RES,
    input  logic [XLEN-1:0]  MEM_Address,
    input  logic [XLEN-1:0]  MEM_RFD,
    input  logic [31:0]      MEM_IR,
    input  logic [XLEN-1:0]  MEM_NPC,
    input  logic             MEM_PC_MUX,
    input  logic [XLEN-1:0]  MEM_Target_Address,
    mem_stage_if.master      dmem,
    output logic             V_MEM_STALL,
    output logic             MEM_FE_PC_MUX,
    output logic [XLEN-1:0]  MEM_FE_Target,
    output logic             WB_V,
    output logic [XLEN-1:0]  WB_RES,
    output logic [31:0]      WB_IR,
    output logic [XLEN-1:0]  WB_NPC,
    output logic [4:0]       WB_DR,
    output logic [CST_W-1:0] WB_Cst,
    output logic             MEM_MISALIGN,
    output state_e           fsm_state
);

    state_e      state_q, state_d;
    logic        is_ld, is_st, mem_op, go, trap;
    logic [1:0]  size;
    logic [2:0]  off;
    logic [2:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q, ld_q;
    logic [63:0] ld_data;

    // Load wins when both control bits are set, so a store never fires with it.
    always_comb begin
        is_ld  = MEM_Cst[CST_LD];
        is_st  = MEM_Cst[CST_ST] & ~MEM_Cst[CST_LD];
        mem_op = MEM_V & (MEM_Cst[CST_LD] | MEM_Cst[CST_ST]);
        size   = MEM_IR[13:12];
`ifdef MEM_MISALIGN_TRAP_EN
        off  = MEM_Address[2:0];
        trap = mem_op & (|(MEM_Address[2:0] & off_mask(size)));
        go   = mem_op & ~trap;
`else
        off  = MEM_Address[2:0] & ~off_mask(size);
        trap = 1'b0;
        go   = mem_op;
`endif
    end

    always_comb begin
        state_d     = state_q;
        V_MEM_STALL = 1'b0;
        case (state_q)
            ST_IDLE: begin
                V_MEM_STALL = go;
                if (go) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                V_MEM_STALL = ~dmem.DMEM_ACK;
                if (dmem.DMEM_ACK) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    load_align u_load_align (
        .rdata (dmem.DMEM_RDATA),
        .off   (off_q),
        .size  (size_q),
        .uns   (uns_q),
        .data  (ld_data)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dmem.DMEM_REQ   <= 1'b0;
            dmem.DMEM_WE    <= 1'b0;
            dmem.DMEM_ADDR  <= '0;
            dmem.DMEM_WDATA <= '0;
            dmem.DMEM_WMASK <= '0;
            WB_V            <= 1'b0;
            WB_RES          <= '0;
            WB_IR           <= '0;
            WB_NPC          <= '0;
            WB_DR           <= '0;
            WB_Cst          <= '0;
            off_q           <= '0;
            size_q          <= '0;
            uns_q           <= 1'b0;
            ld_q            <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        dmem.DMEM_REQ   <= 1'b1;
                        dmem.DMEM_WE    <= is_st;
                        dmem.DMEM_ADDR  <= {MEM_Address[XLEN-1:3], 3'b000};
                        dmem.DMEM_WDATA <= MEM_RFD << {off, 3'b000};
                        dmem.DMEM_WMASK <= size_mask(size) << off;
                        off_q           <= off;
                        size_q          <= size;
                        uns_q           <= MEM_IR[14];
                        ld_q            <= is_ld;
                        WB_V            <= 1'b0;
                    end else begin
                        // A trapped access still carries IR/NPC for the handler.
                        WB_V   <= MEM_V & ~trap;
                        WB_RES <= MEM_RES;
                        WB_IR  <= MEM_IR;
                        WB_NPC <= MEM_NPC;
                        WB_DR  <= MEM_IR[11:7];
                        WB_Cst <= MEM_Cst;
                    end
                end
                ST_BUSY: begin
                    if (dmem.DMEM_ACK) begin
                        dmem.DMEM_REQ <= 1'b0;
                        WB_V   <= 1'b1;
                        WB_RES <= ld_q ? ld_data : MEM_RES;
                        WB_IR  <= MEM_IR;
                        WB_NPC <= MEM_NPC;
                        WB_DR  <= MEM_IR[11:7];
                        WB_Cst <= MEM_Cst;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    always_ff @(posedge CLK) begin
        if (RESET) misalign_q <= 1'b0;
        else       misalign_q <= (state_q == ST_IDLE) & trap;
    end
    assign MEM_MISALIGN = misalign_q;
`else
    assign MEM_MISALIGN = 1'b0;
`endif

    // Redirects bypass the stall: upstream keeps its inputs steady meanwhile.
    assign MEM_FE_PC_MUX = MEM_V & MEM_PC_MUX;
    assign MEM_FE_Target = MEM_Target_Address;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, corner-case sequences and
// randomized loads/stores checked against a byte-level reference model.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        RESET;
    logic        MEM_V;
    logic [18:0] MEM_Cst;
    logic [63:0] MEM_RES, MEM_Address, MEM_RFD, MEM_NPC, MEM_Target_Address;
    logic [31:0] MEM_IR;
    logic        MEM_PC_MUX;
    logic        V_MEM_STALL, MEM_FE_PC_MUX, WB_V, MEM_MISALIGN;
    logic [63:0] MEM_FE_Target, WB_RES, WB_NPC;
    logic [31:0] WB_IR;
    logic [4:0]  WB_DR;
    logic [18:0] WB_Cst;
    state_e      fsm_state;

    mem_stage_if #(.XLEN(64)) dmem ();

    mem_stage #(.XLEN(64), .CST_W(19)) dut (
        .CLK(clk), .RESET(RESET), .MEM_V(MEM_V), .MEM_Cst(MEM_Cst),
        .MEM_RES(MEM_RES), .MEM_Address(MEM_Address), .MEM_RFD(MEM_RFD),
        .MEM_IR(MEM_IR), .MEM_NPC(MEM_NPC), .MEM_PC_MUX(MEM_PC_MUX),
        .MEM_Target_Address(MEM_Target_Address), .dmem(dmem),
        .V_MEM_STALL(V_MEM_STALL), .MEM_FE_PC_MUX(MEM_FE_PC_MUX),
        .MEM_FE_Target(MEM_FE_Target), .WB_V(WB_V), .WB_RES(WB_RES),
        .WB_IR(WB_IR), .WB_NPC(WB_NPC), .WB_DR(WB_DR), .WB_Cst(WB_Cst),
        .MEM_MISALIGN(MEM_MISALIGN), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [4:0] dr);
        return {17'b0, f3, dr, 7'h03};
    endfunction

    // Reference model: byte-by-byte lane arithmetic straight from the access rules.
    function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                  input logic [63:0] addr, input logic [63:0] rfd,
                                  input logic [63:0] res, input logic [63:0] rdata,
                                  output logic [63:0] e_res, output logic [63:0] e_addr,
                                  output logic [63:0] e_wdata, output logic [7:0] e_wmask,
                                  output logic e_we);
        int nb, off;
        logic [63:0] val;
        nb = 1 << f3[1:0];
        off = int'(addr % 64'd8);
        off = off - (off % nb);
        e_addr = addr - (addr % 64'd8);
        e_we = st && !ld;
        e_wmask = '0;
        for (int i = 0; i < nb; i++) e_wmask[off+i] = 1'b1;
        e_wdata = rfd << (8 * off);
        val = '0;
        for (int i = 0; i < nb; i++) val[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!f3[2]) for (int b = 8 * nb; b < 64; b++) val[b] = val[8*nb-1];
        e_res = ld ? val : res;
    endfunction

    logic [63:0] obs_addr, obs_wdata, obs_res;
    logic [7:0]  obs_wmask;
    logic        obs_we, obs_req_ok, obs_stable, obs_wb_v, obs_req_after;
    logic [4:0]  obs_dr;
    int          obs_stall;

    // Driver: one memory op with `lat` non-ACK REQ cycles before the ACK cycle.
    task automatic mem_txn(input logic [18:0] cst, input logic [2:0] f3, input logic [4:0] dr,
                           input logic [63:0] addr, input logic [63:0] rfd,
                           input logic [63:0] res, input logic [63:0] rdata, input int lat);
        MEM_V = 1'b1; MEM_Cst = cst; MEM_IR = mk_ir(f3, dr); MEM_Address = addr;
        MEM_RFD = rfd; MEM_RES = res; MEM_NPC = addr + 64'd4; MEM_PC_MUX = 1'b0;
        dmem.DMEM_ACK = 1'b0; dmem.DMEM_RDATA = '0;
        #1;
        obs_stall = int'(V_MEM_STALL);
        @(posedge clk); #1;
        obs_req_ok = dmem.DMEM_REQ;
        obs_addr = dmem.DMEM_ADDR; obs_wdata = dmem.DMEM_WDATA;
        obs_wmask = dmem.DMEM_WMASK; obs_we = dmem.DMEM_WE;
        obs_stable = ~WB_V;
        for (int k = 0; k < lat; k++) begin
            obs_stall += int'(V_MEM_STALL);
            @(posedge clk); #1;
            obs_req_ok &= dmem.DMEM_REQ;
            obs_stable &= (dmem.DMEM_ADDR == obs_addr) && (dmem.DMEM_WDATA == obs_wdata) &&
                          (dmem.DMEM_WMASK == obs_wmask) && (dmem.DMEM_WE == obs_we) && !WB_V;
        end
        dmem.DMEM_ACK = 1'b1; dmem.DMEM_RDATA = rdata;
        #1;
        obs_stall += int'(V_MEM_STALL);
        @(posedge clk); #1;
        dmem.DMEM_ACK = 1'b0; MEM_V = 1'b0;
        obs_wb_v = WB_V; obs_res = WB_RES; obs_dr = WB_DR; obs_req_after = dmem.DMEM_REQ;
    endtask

    task automatic alu_txn(input string nm, input logic [18:0] cst, input logic [4:0] dr,
                           input logic [63:0] res, input logic [63:0] tgt);
        MEM_V = 1'b1; MEM_Cst = cst; MEM_IR = mk_ir(3'd0, dr); MEM_RES = res;
        MEM_PC_MUX = 1'b1; MEM_Target_Address = tgt; MEM_Address = tgt; MEM_NPC = tgt;
        #1;
        chk({nm, " stall"}, V_MEM_STALL, 1'b0);
        chk({nm, " fe_pc_mux"}, MEM_FE_PC_MUX, 1'b1);
        chk({nm, " fe_target"}, MEM_FE_Target, tgt);
        @(posedge clk); #1;
        MEM_V = 1'b0; MEM_PC_MUX = 1'b0;
        chk({nm, " wb_v"}, WB_V, 1'b1);
        chk({nm, " wb_res"}, WB_RES, res);
        chk({nm, " wb_dr"}, WB_DR, dr);
        chk({nm, " req"}, dmem.DMEM_REQ, 1'b0);
    endtask

    typedef struct {
        logic        is_mem;
        logic [18:0] cst;
        logic [2:0]  f3;
        logic [63:0] addr, rfd, res, rdata;
        int          lat;
        logic [63:0] e_res, e_addr, e_wdata;
        logic [7:0]  e_wmask;
        logic        e_we;
        int          e_stall;
    } vec_t;

    function automatic vec_t mk(input logic is_mem, input logic [18:0] cst, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] rfd,
                                input logic [63:0] res, input logic [63:0] rdata, input int lat,
                                input logic [63:0] e_res, input logic [63:0] e_addr,
                                input logic [63:0] e_wdata, input logic [7:0] e_wmask,
                                input logic e_we, input int e_stall);
        vec_t v;
        v.is_mem = is_mem; v.cst = cst; v.f3 = f3; v.addr = addr; v.rfd = rfd;
        v.res = res; v.rdata = rdata; v.lat = lat; v.e_res = e_res; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_wmask = e_wmask; v.e_we = e_we; v.e_stall = e_stall;
        return v;
    endfunction

    localparam logic [18:0] C_LD = 19'h20;
    localparam logic [18:0] C_ST = 19'h10;

    vec_t vecs[11];

    task automatic check_mem(input string nm, input vec_t v, input logic [4:0] dr);
        chk({nm, " req_held"}, obs_req_ok, 1'b1);
        chk({nm, " busy_stable"}, obs_stable, 1'b1);
        chk({nm, " addr"}, obs_addr, v.e_addr);
        chk({nm, " we"}, obs_we, v.e_we);
        if (v.e_we) begin
            chk({nm, " wmask"}, obs_wmask, v.e_wmask);
            chk({nm, " wdata"}, obs_wdata, v.e_wdata);
        end
        chk({nm, " stall_cycles"}, 64'(obs_stall), 64'(v.e_stall));
        chk({nm, " wb_v"}, obs_wb_v, 1'b1);
        chk({nm, " wb_res"}, obs_res, v.e_res);
        chk({nm, " wb_dr"}, obs_dr, dr);
        chk({nm, " req_drop"}, obs_req_after, 1'b0);
    endtask

    initial begin
        logic [63:0] e_res, e_addr, e_wdata, a, rfd, res, rd;
        logic [7:0]  e_wmask;
        logic        e_we, ld, st;
        logic [2:0]  f3;
        logic [18:0] cst;
        logic [4:0]  dr;
        int          kind, lat;
        vec_t        v;

        vecs[0]  = mk(0, 19'h0, 3'd0, 64'h0, 64'h0, 64'h1234, 64'h0, 0,
                      64'h1234, 64'h0, 64'h0, 8'h00, 0, 0);
        vecs[1]  = mk(1, C_LD, 3'b000, 64'h1003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 3,
                      64'hFFFF_FFFF_FFFF_FF80, 64'h1000, 64'h0, 8'h00, 0, 4);
        vecs[2]  = mk(1, C_LD, 3'b101, 64'h2006, 64'h0, 64'h0, 64'hBEEF_0000_0000_0000, 0,
                      64'hBEEF, 64'h2000, 64'h0, 8'h00, 0, 1);
        vecs[3]  = mk(1, C_ST, 3'b010, 64'h3004, 64'hDEADBEEF, 64'h55, 64'h0, 1,
                      64'h55, 64'h3000, 64'hDEADBEEF_0000_0000, 8'hF0, 1, 2);
        vecs[4]  = mk(1, C_LD, 3'b011, 64'h5000, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 2,
                      64'h0123_4567_89AB_CDEF, 64'h5000, 64'h0, 8'h00, 0, 3);
        vecs[5]  = mk(1, C_LD, 3'b010, 64'h6004, 64'h0, 64'h0, 64'h8000_0001_0000_0000, 1,
                      64'hFFFF_FFFF_8000_0001, 64'h6000, 64'h0, 8'h00, 0, 2);
        vecs[6]  = mk(1, C_ST, 3'b000, 64'h7005, 64'hAB, 64'h77, 64'h0, 0,
                      64'h77, 64'h7000, 64'h0000_AB00_0000_0000, 8'h20, 1, 1);
        vecs[7]  = mk(1, C_LD | C_ST, 3'b100, 64'h8001, 64'hFFFF, 64'h0, 64'h7F00, 1,
                      64'h7F, 64'h8000, 64'h0, 8'h00, 0, 2);
        vecs[8]  = mk(1, C_ST, 3'b011, 64'h9000, 64'h1122_3344_5566_7788, 64'h99, 64'h0, 2,
                      64'h99, 64'h9000, 64'h1122_3344_5566_7788, 8'hFF, 1, 3);
        vecs[9]  = mk(1, C_LD, 3'b001, 64'hA002, 64'h0, 64'h0, 64'h0000_0000_8001_0000, 0,
                      64'hFFFF_FFFF_FFFF_8001, 64'hA000, 64'h0, 8'h00, 0, 1);
        vecs[10] = mk(0, 19'h40001, 3'd0, 64'h0, 64'h0, 64'hFFFF_0000_ABCD, 64'h0, 0,
                      64'hFFFF_0000_ABCD, 64'h0, 64'h0, 8'h00, 0, 0);

        // Clock/reset
        RESET = 1'b1; MEM_V = 1'b0; MEM_Cst = '0; MEM_RES = '0; MEM_Address = '0;
        MEM_RFD = '0; MEM_IR = '0; MEM_NPC = '0; MEM_PC_MUX = 1'b0; MEM_Target_Address = '0;
        dmem.DMEM_ACK = 1'b0; dmem.DMEM_RDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst fsm", 64'(fsm_state), 64'(ST_IDLE));
        chk("rst req", dmem.DMEM_REQ, 1'b0);
        chk("rst we", dmem.DMEM_WE, 1'b0);
        chk("rst addr", dmem.DMEM_ADDR, 64'h0);
        chk("rst wdata", dmem.DMEM_WDATA, 64'h0);
        chk("rst wmask", dmem.DMEM_WMASK, 8'h0);
        chk("rst wb_v", WB_V, 1'b0);
        chk("rst wb_res", WB_RES, 64'h0);
        chk("rst wb_ir", WB_IR, 32'h0);
        chk("rst misalign", MEM_MISALIGN, 1'b0);
        RESET = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            dr = 5'(i + 1);
            if (v.is_mem) begin
                mem_txn(v.cst, v.f3, dr, v.addr, v.rfd, v.res, v.rdata, v.lat);
                check_mem($sformatf("vec%0d", i), v, dr);
            end else begin
                alu_txn($sformatf("vec%0d", i), v.cst, dr, v.res, 64'hCAFE_0000 + 64'(i));
            end
        end

        // Redirect is not reported without a valid instruction
        MEM_V = 1'b0; MEM_PC_MUX = 1'b1; MEM_Target_Address = 64'h1234_5678;
        #1;
        chk("fe_pc_mux idle", MEM_FE_PC_MUX, 1'b0);
        chk("fe_target idle", MEM_FE_Target, 64'h1234_5678);
        MEM_PC_MUX = 1'b0;

        // Misaligned doubleword load
`ifdef MEM_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        MEM_V = 1'b1; MEM_Cst = C_LD; MEM_IR = mk_ir(3'b011, 5'd9);
        MEM_Address = 64'h4004; MEM_NPC = 64'h4444;
        #1;
        chk("trap stall", V_MEM_STALL, 1'b0);
        @(posedge clk); #1;
        MEM_V = 1'b0; MEM_Cst = '0;
        chk("trap req", dmem.DMEM_REQ, 1'b0);
        chk("trap pulse", MEM_MISALIGN, 1'b1);
        chk("trap wb_v", WB_V, 1'b0);
        chk("trap wb_ir", WB_IR, mk_ir(3'b011, 5'd9));
        chk("trap wb_npc", WB_NPC, 64'h4444);
        @(posedge clk); #1;
        chk("trap pulse end", MEM_MISALIGN, 1'b0);
        chk("trap req after", dmem.DMEM_REQ, 1'b0);
`else
        @(posedge clk); #1;
        v = mk(1, C_LD, 3'b011, 64'h4004, 64'h0, 64'h0, 64'hA5A5_0000_1111_2222, 1,
               64'hA5A5_0000_1111_2222, 64'h4000, 64'h0, 8'h00, 0, 2);
        mem_txn(v.cst, v.f3, 5'd9, v.addr, v.rfd, v.res, v.rdata, v.lat);
        check_mem("misaligned ld", v, 5'd9);
        chk("misalign tied", MEM_MISALIGN, 1'b0);
`endif

        // ACK while idle is ignored
        @(posedge clk); #1;
        MEM_V = 1'b0; dmem.DMEM_ACK = 1'b1; dmem.DMEM_RDATA = 64'hFFFF;
        @(posedge clk); #1;
        dmem.DMEM_ACK = 1'b0;
        chk("idle ack fsm", 64'(fsm_state), 64'(ST_IDLE));
        chk("idle ack req", dmem.DMEM_REQ, 1'b0);
        chk("idle ack wb_v", WB_V, 1'b0);

        // Reset while busy, with a simultaneous ACK
        MEM_V = 1'b1; MEM_Cst = C_LD; MEM_IR = mk_ir(3'b011, 5'd3); MEM_Address = 64'hB000;
        @(posedge clk); #1;
        chk("rb req", dmem.DMEM_REQ, 1'b1);
        chk("rb fsm busy", 64'(fsm_state), 64'(ST_BUSY));
        RESET = 1'b1; dmem.DMEM_ACK = 1'b1; dmem.DMEM_RDATA = 64'h1;
        @(posedge clk); #1;
        chk("rb fsm", 64'(fsm_state), 64'(ST_IDLE));
        chk("rb req", dmem.DMEM_REQ, 1'b0);
        chk("rb wb_v", WB_V, 1'b0);
        RESET = 1'b0; dmem.DMEM_ACK = 1'b0; MEM_V = 1'b0; MEM_Cst = '0;
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 3));
            f3   = 3'($urandom_range(0, 7));
            a    = {$urandom, $urandom};
`ifdef MEM_MISALIGN_TRAP_EN
            a = a - (a % (64'd1 << f3[1:0]));
`endif
            rfd = {$urandom, $urandom};
            res = {$urandom, $urandom};
            rd  = {$urandom, $urandom};
            dr  = 5'($urandom_range(0, 31));
            lat = int'($urandom_range(0, 3));
            ld  = (kind == 1) || (kind == 3);
            st  = (kind == 2) || (kind == 3);
            cst = 19'($urandom) & ~19'h30;
            cst[5] = ld; cst[4] = st;
            if (kind == 0) begin
                alu_txn($sformatf("rnd%0d alu", n), cst, dr, res, a);
            end else begin
                model(ld, st, f3, a, rfd, res, rd, e_res, e_addr, e_wdata, e_wmask, e_we);
                exp_q.push_back(e_res);
                mem_txn(cst, f3, dr, a, rfd, res, rd, lat);
                chk($sformatf("rnd%0d wb_res", n), obs_res, exp_q.pop_front());
                chk($sformatf("rnd%0d wb_v", n), obs_wb_v, 1'b1);
                chk($sformatf("rnd%0d addr", n), obs_addr, e_addr);
                chk($sformatf("rnd%0d we", n), obs_we, e_we);
                chk($sformatf("rnd%0d stall", n), 64'(obs_stall), 64'(1 + lat));
                chk($sformatf("rnd%0d stable", n), obs_stable & obs_req_ok, 1'b1);
                if (e_we) begin
                    chk($sformatf("rnd%0d wmask", n), obs_wmask, e_wmask);
                    chk($sformatf("rnd%0d wdata", n), obs_wdata, e_wdata);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage, directly downstream of `execute`. Registers `execute` outputs, performs loads/stores over a single-outstanding request/acknowledge data-memory port, and aligns and extends load data. Presents results to writeback and stalls upstream while an access is outstanding.

## Interface
Parameters:
- `XLEN`, 64: datapath width.
- `CST_W`, 19: control-store word width.

Ports:
- `CLK`  in  1  clock, all state on rising edge.
- `RESET`  in  1  synchronous, active-high.
- `MEM_V`  in  1  instruction valid from execute.
- `MEM_Cst`  in  19  control word. Bit [5] = load, bit [4] = store.
- `MEM_RES`  in  64  ALU/mul result.
- `MEM_Address`  in  64  effective memory address.
- `MEM_RFD`  in  64  store data.
- `MEM_IR`  in  32  instruction. `IR[14:12]` is size/sign; `IR[11:7]` is the destination register (DR).
- `MEM_NPC`  in  64  next PC.
- `MEM_PC_MUX`  in  1  branch/jump taken.
- `MEM_Target_Address`  in  64  redirect target.
- `DMEM_REQ`  out  1  access request, registered.
- `DMEM_WE`  out  1  write enable.
- `DMEM_ADDR`  out  64  doubleword address, low 3 bits zero.
- `DMEM_WDATA`  out  64  lane-shifted store data.
- `DMEM_WMASK`  out  8  byte enables.
- `DMEM_ACK`  in  1  access complete; read data valid on the same cycle.
- `DMEM_RDATA`  in  64  read doubleword.
- `V_MEM_STALL`  out  1  combinational. Upstream holds all `MEM_*` inputs while high.
- `MEM_FE_PC_MUX`  out  1  combinational, `MEM_V & MEM_PC_MUX`.
- `MEM_FE_Target`  out  64  combinational, equals `MEM_Target_Address`.
- `WB_V`, `WB_RES[63:0]`, `WB_IR[31:0]`, `WB_NPC[63:0]`, `WB_DR[4:0]`, `WB_Cst[18:0]`  out  registered, to writeback.
- `MEM_MISALIGN`  out  1  registered one-cycle trap pulse.

## Operation
- Memory op: `MEM_V & (Cst[5] | Cst[4])`.
- FSM has two states: IDLE and BUSY.
- IDLE, non-memory op: next edge registers `WB_*` from `MEM_*`. `WB_RES = MEM_RES`, `WB_V = MEM_V`.
- IDLE, aligned memory op:
  - `V_MEM_STALL = 1`; `WB_V <= 0`.
  - Latch the address, write data, mask and `WE`; go to BUSY with `DMEM_REQ <= 1`.
- BUSY: `DMEM_REQ` and all `DMEM_*` outputs stay constant until `DMEM_ACK`.
  - `V_MEM_STALL = !DMEM_ACK`.
  - On ACK: `DMEM_REQ <= 0`, return to IDLE, `WB_V <= 1`.
  - Load: `WB_RES` = aligned/extended read data.
  - Store: `WB_RES = MEM_RES`.
- Size from `IR[13:12]`: 00 B, 01 H, 10 W, 11 D. `IR[14] = 1` selects zero-extension.
- Store mask is `{1,3,15,255}` for B/H/W/D, shifted left by `addr[2:0]`. `WDATA = MEM_RFD << 8*addr[2:0]`.
- Load: `RDATA >> 8*addr[2:0]`, truncated to size, then sign- or zero-extended to 64 bits.
- Misaligned means `addr[2:0]` not a multiple of the size. Behaviour is set by the Configuration macro.
- `DMEM_ACK` while in IDLE is ignored.
- Load and store both set together: treat as load, with `WE = 0`.

## Timing
- Reset values:
  - FSM = IDLE.
  - `DMEM_REQ`, `DMEM_WE`, `WB_V`, `MEM_MISALIGN` = 0.
  - `DMEM_ADDR`, `DMEM_WDATA`, `DMEM_WMASK`, all `WB_*` data outputs = 0.
- Non-memory latency: 1 cycle.
- Memory latency: `DMEM_REQ` asserts 1 cycle after acceptance. `WB_V` asserts on the edge after the ACK cycle. Minimum is 2 cycles, with ACK in the first REQ cycle.
- RESET while BUSY: next edge goes to IDLE and drops `DMEM_REQ`. An ACK in the same cycle is discarded and `WB_V` stays 0.
- `MEM_FE_*` are purely combinational. They are not gated by stall, because upstream holds its inputs steady.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned memory op issues no request and causes no stall.
  - Next edge: `MEM_MISALIGN <= 1` for one cycle, `WB_V <= 0`, and `WB_IR`/`WB_NPC` are still registered for the trap handler.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - `addr[2:0]` is masked down to size alignment, and the access proceeds normally.
  - `MEM_MISALIGN` is tied to 0.

## Structure
- Package `mem_pkg` holds:
  - Cst bit positions (`CST_LD = 5`, `CST_ST = 4`);
  - size encodings;
  - the FSM state enum;
  - byte-mask constants.
- Sub-module `load_align`: combinational lane select plus sign/zero extension.
  - Inputs: `rdata[63:0]`, `off[2:0]`, `size[1:0]`, `uns`.
  - Output: `data[63:0]`.

## Test plan
- ALU op, `MEM_RES = 0x1234`: `WB_RES = 0x1234`, `WB_V = 1`, 1 cycle later; `DMEM_REQ` never asserts.
- LB at addr `0x1003`, `RDATA = 0x00000000_80000000`, ACK after 3 cycles:
  - `DMEM_ADDR = 0x1000`;
  - `WB_RES = 0xFFFF_FFFF_FFFF_FF80`;
  - `V_MEM_STALL` high for 4 cycles.
- LHU at `0x2006`, `RDATA = 0xBEEF_0000_0000_0000`: `WB_RES = 0xBEEF`.
- SW at `0x3004`, `RFD = 0xDEADBEEF`: `WMASK = 0xF0`, `WDATA = 0xDEADBEEF_00000000`, `WE = 1`.
- LD at `0x4004` with `MEM_MISALIGN_TRAP_EN`: no REQ, `MEM_MISALIGN` pulse, `WB_V = 0`. Without the macro: `DMEM_ADDR = 0x4000`.
- RESET asserted during BUSY with a simultaneous ACK: next cycle FSM is IDLE, `DMEM_REQ = 0`, `WB_V = 0`.
